memory_col_burst_ctrl: RTL and testbench

Burst front-end that sits directly upstream of the 1024x8 column memory, `memory_col_n`.
- Accepts one burst command at a time (read or write, start address, length) over a valid/ready interface.
- Sequences per-beat address, byte_en and wr_data into the memory.
- Collects the memory's 1-cycle-latency read data into a small response FIFO so a stalling consumer never loses data.

---
 rtl/memory_col_pkg.sv | 19 +
 rtl/memory_col_rsp_fifo.sv | 58 +++++
 rtl/memory_col_burst_ctrl.sv | 131 +++++++++++++
 tb/tb_memory_col_burst_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_col_pkg.sv
// Shared widths and types for the column-memory burst front-end.
package memory_col_pkg;
    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 8;
    localparam int LEN_W_DEF     = 8;
    localparam int RSP_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD       = 2'd2,
        RD_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } rsp_t;
endpackage

// File: rtl/memory_col_rsp_fifo.sv
// Small response FIFO holding read beats; push and pop may coincide even when full.
module memory_col_rsp_fifo
    import memory_col_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  rsp_t                   push_data,
    input  logic                   pop,
    output rsp_t                   head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    rsp_t             store_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign count     = count_r;
    assign head      = store_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    // A full FIFO can still accept a push when a pop frees the slot on the same edge.
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                store_r[i] <= '{data: {DATA_W_DEF{1'b0}}, last: 1'b0};
            end
        end else begin
            if (do_push_s) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/memory_col_burst_ctrl.sv
// Burst front-end for the 1024x8 column memory: sequences write/read beats and
// buffers the memory's 1-cycle read data so consumer stalls never lose beats.
module memory_col_burst_ctrl
    import memory_col_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_byte_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    state_e            state_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [LEN_W-1:0]  beats_left_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic [DATA_W-1:0] wr_data_hold_r;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W:0]    credit_used_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              issue_s;
    logic              last_beat_s;
    rsp_t              push_data_s;
    rsp_t              head_s;

    assign last_beat_s   = (beats_left_r == {LEN_W{1'b0}});
    // Buffered plus in-flight beats must never exceed FIFO space, so pushes are never dropped.
    assign credit_used_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r};
    assign issue_s       = (state_r == RD) && !fifo_full_s
                           && (credit_used_s < (CNT_W+1)'(RSP_DEPTH));

    assign cmd_ready   = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign wdata_ready = (state_r == WR);
    assign mem_byte_en = (state_r == WR) && wdata_valid;
    assign mem_addr    = cur_addr_r;
    assign mem_wr_data = (state_r == WR) ? wdata : wr_data_hold_r;

    assign push_data_s.data = mem_rd_data;
    assign push_data_s.last = inflight_last_r;
    assign rdata_valid      = !fifo_empty_s;
    assign rdata            = head_s.data;
    assign rdata_last       = head_s.last;

    // Burst FSM with address/beat counters and read in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            cur_addr_r      <= {ADDR_W{1'b0}};
            beats_left_r    <= {LEN_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            wr_data_hold_r  <= {DATA_W{1'b0}};
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && last_beat_s;
            if (state_r == WR) begin
                wr_data_hold_r <= wdata;
            end
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr_r   <= cmd_addr;
                        beats_left_r <= cmd_len;
                        state_r      <= cmd_write ? WR : RD;
                    end
                end
                WR: begin
                    if (wdata_valid) begin
                        cur_addr_r   <= cur_addr_r + ADDR_W'(1'b1);
                        beats_left_r <= beats_left_r - LEN_W'(1'b1);
                        if (last_beat_s) begin
                            state_r <= IDLE;
                        end
                    end
                end
                RD: begin
                    if (issue_s) begin
                        cur_addr_r   <= cur_addr_r + ADDR_W'(1'b1);
                        beats_left_r <= beats_left_r - LEN_W'(1'b1);
                        if (last_beat_s) begin
                            state_r <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (!inflight_r && fifo_empty_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    memory_col_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (push_data_s),
        .pop       (rdata_ready),
        .head      (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );
endmodule

// File: tb/tb_memory_col_burst_ctrl.sv
// Self-checking bench: behavioural 1024x8 memory, shadow-memory reference model and scoreboards.
module tb_memory_col_burst_ctrl;
    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid;
    logic       rdata_ready;
    logic [7:0] rdata;
    logic       rdata_last;
    logic       busy;
    logic [9:0] mem_addr;
    logic       mem_byte_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;

    typedef struct { logic [9:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] d; logic last; } rd_t;

    wr_t        wr_q [$];
    rd_t        rd_q [$];
    logic [7:0] ref_mem [1024];
    logic [7:0] mem_arr [1024];
    logic       mem_init_done = 1'b0;
    logic       in_wr = 1'b0;
    int         rdy_mode = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    memory_col_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy),
        .mem_addr(mem_addr), .mem_byte_en(mem_byte_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural column memory: synchronous write, 1-cycle read latency.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_byte_en) begin
            mem_arr[mem_addr] <= mem_wr_data;
        end
        mem_rd_data <= mem_arr[mem_addr];
    end

    // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        rdata_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rdata_ready = 1'b1;
                1:       rdata_ready = 1'($urandom_range(0, 1));
                default: rdata_ready = 1'b0;
            endcase
        end
    end

    // Scoreboards sampled mid-cycle: memory writes and read beats.
    always @(negedge clk) begin
        wr_t w;
        rd_t e;
        check("byte_en", 32'(mem_byte_en), 32'(in_wr && wdata_valid));
        if (mem_byte_en) begin
            if (wr_q.size() == 0) begin
                check("wr_extra", 32'(mem_byte_en), 32'd0);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.a));
                check("wr_data", 32'(mem_wr_data), 32'(w.d));
                ref_mem[w.a] = w.d;
            end
        end
        if (rdata_valid && rdata_ready) begin
            if (rd_q.size() == 0) begin
                check("rd_extra", 32'(rdata_valid), 32'd0);
            end else begin
                e = rd_q.pop_front();
                check("rdata", 32'(rdata), 32'(e.d));
                check("rdata_last", 32'(rdata_last), 32'(e.last));
            end
        end
    end

    task automatic send_cmd(input logic wr, input int addr, input int len);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = 10'(addr);
        cmd_len   = 8'(len);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len, input int base, input int mode,
                               output int cyc);
        logic [7:0] d [$];
        logic [6:0] pat = 7'b1011001;
        int sent = 0;
        cyc = 0;
        for (int i = 0; i <= len; i++) begin
            d.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
            wr_q.push_back('{a: 10'(addr + i), d: d[i]});
        end
        send_cmd(1'b1, addr, len);
        in_wr = 1'b1;
        while (sent <= len && cyc < 2000) begin
            case (mode)
                0:       wdata_valid = 1'b1;
                1:       wdata_valid = 1'($urandom_range(0, 1));
                default: wdata_valid = pat[cyc % 7];
            endcase
            wdata = d[sent];
            @(posedge clk); #1;
            if (wdata_valid) sent++;
            cyc++;
        end
        wdata_valid = 1'b0;
        in_wr = 1'b0;
        check("wr_beats", 32'(sent), 32'(len + 1));
    endtask

    task automatic read_burst(input int addr, input int len);
        for (int i = 0; i <= len; i++) begin
            rd_q.push_back('{d: ref_mem[10'(addr + i)], last: (i == len)});
        end
        wdata_valid = 1'b1;
        send_cmd(1'b0, addr, len);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && rd_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk); #1;
        wdata_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] exp_v [6];
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'd0; cmd_len = 8'd0;
        wdata_valid = 1'b0; wdata = 8'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rdata_last", 32'(rdata_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_en", 32'(mem_byte_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a 4-beat write, while beat 2 is presented.
        for (int i = 0; i < 4; i++) wr_q.push_back('{a: 10'(32'h050 + i), d: 8'(8'hC0 + i)});
        send_cmd(1'b1, 32'h050, 3);
        in_wr = 1'b1;
        wdata_valid = 1'b1; wdata = 8'hC0;
        @(posedge clk); #1;
        wdata = 8'hC1;
        @(posedge clk); #1;
        wdata = 8'hC2;
        rst = 1'b1; in_wr = 1'b0;
        #1;
        check("t1_byte_en_async", 32'(mem_byte_en), 32'd0);
        check("t1_wready_async", 32'(wdata_ready), 32'd0);
        wr_q.delete();
        wdata_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t1_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t1_mem_a0", 32'(mem_arr[10'h050]), 32'h0C0);
        check("t1_mem_a1", 32'(mem_arr[10'h051]), 32'h0C1);
        check("t1_mem_a2", 32'(mem_arr[10'h052]), 32'(init_val(32'h052)));
        check("t1_mem_a3", 32'(mem_arr[10'h053]), 32'(init_val(32'h053)));

        // Back-to-back write then read at 0x010; full-rate read timing.
        write_burst(32'h010, 3, 32'hA1, 0, cyc);
        check("t2_wr_cycles", 32'(cyc), 32'd4);
        read_burst(32'h010, 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t2_rvalid", 32'(rdata_valid), 32'(k >= 3));
            if (k == 6) check("t2_rlast", 32'(rdata_last), 32'd1);
        end
        wait_idle();

        // Address wrap inside a burst.
        write_burst(32'h3FE, 3, 32'h11, 0, cyc);
        check("t3_mem_000", 32'(mem_arr[10'h000]), 32'h013);
        check("t3_mem_001", 32'(mem_arr[10'h001]), 32'h014);
        read_burst(32'h3FE, 3);
        wait_idle();

        // Consumer stalled: only RSP_DEPTH reads may be issued.
        rdy_mode = 2;
        read_burst(32'h100, 7);
        repeat (10) @(negedge clk);
        check("t4_issued_addr", 32'(mem_addr), 32'h104);
        check("t4_rvalid", 32'(rdata_valid), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rdy_mode = 0;
        wait_idle();

        // Write with wdata_valid gaps 1,0,0,1,1,0,1.
        write_burst(32'h200, 3, -1, 2, cyc);
        check("t5_cycles", 32'(cyc), 32'd7);
        read_burst(32'h200, 3);
        wait_idle();

        // Single-beat read: valid+last together, cmd_ready one cycle after the pop.
        read_burst(32'h011, 0);
        exp_v = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 3) check("t6_rvalid", 32'(rdata_valid), 32'(exp_v[k-1]));
            if (k == 3) check("t6_rlast", 32'(rdata_last), 32'd1);
            if (k == 4) check("t6_busy_hold", 32'(busy), 32'd1);
            if (k == 5) begin
                check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
                check("t6_busy_low", 32'(busy), 32'd0);
            end
        end
        wait_idle();

        // Randomised bursts with random backpressure and write gaps.
        for (int n = 0; n < 30; n++) begin
            int a;
            int l;
            rdy_mode = $urandom_range(0, 1);
            a = $urandom_range(0, 1023);
            l = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                write_burst(a, l, -1, $urandom_range(0, 1), cyc);
            end else begin
                read_burst(a, l);
                wait_idle();
            end
        end
        check("end_wr_q", 32'(wr_q.size()), 32'd0);
        check("end_rd_q", 32'(rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
